// File: rtl/fetch_pkg.sv
// Shared widths, PC step and queue entry type for the instruction-fetch stage.
package fetch_pkg;
  localparam int unsigned FETCH_DATA_WIDTH      = 32;
  localparam int unsigned FETCH_IMEM_ADDR_WIDTH = 8;
  localparam int unsigned FETCH_PC_STEP         = 4;
  localparam int unsigned FETCH_QUEUE_DEPTH     = 4;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0]      inst;
    logic [FETCH_IMEM_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush and same-cycle push/pop at any occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = FETCH_QUEUE_DEPTH,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Storage is not reset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC, sync-read imem, decoupling queue, redirect flush.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = FETCH_DATA_WIDTH,
  parameter int unsigned IMEM_ADDR_WIDTH = FETCH_IMEM_ADDR_WIDTH,
  parameter int unsigned PC_STEP         = FETCH_PC_STEP,
  parameter int unsigned QUEUE_DEPTH     = FETCH_QUEUE_DEPTH,
  parameter int unsigned RESET_PC        = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       imem_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]      imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_inst,
  output logic [IMEM_ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_flushed
`endif
);

  localparam int unsigned AW = IMEM_ADDR_WIDTH;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [AW-1:0]         pc;
  } entry_t;

  logic [AW-1:0] pc_q;
  logic [AW-1:0] issue_pc_q;
  logic          inflight_q;
  logic          drop_q;
  logic          run_q;
  entry_t        hold_q;

  logic [CW-1:0] q_count;
  entry_t        q_head;
  entry_t        q_push_data;
  logic          deq;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   occupancy;
  logic [AW-1:0] redirect_aligned;

  assign out_valid = (q_count != '0);
  assign deq       = out_valid & out_ready;

  // Slots that will be taken once this cycle's response and dequeue settle.
  assign occupancy = (CW+1)'(q_count) + (CW+1)'(inflight_q) - (CW+1)'(deq);
  assign issue     = run_q & ~reset & ~redirect_valid & (occupancy < (CW+1)'(QUEUE_DEPTH));

  assign push = inflight_q & ~drop_q & ~redirect_valid & ~reset;
  assign pop  = deq & ~redirect_valid;

  assign q_push_data      = '{inst: imem_rdata, pc: issue_pc_q};
  assign redirect_aligned = redirect_pc & ~AW'(PC_STEP - 1);

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .count     (q_count),
    .head      (q_head)
  );

  // PC, in-flight tracking and start-up gating; run_q delays the first issue one cycle past reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= AW'(RESET_PC);
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc_q       <= redirect_aligned;
        inflight_q <= 1'b0;
        drop_q     <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          pc_q       <= pc_q + AW'(PC_STEP);
          issue_pc_q <= pc_q;
        end
      end
    end
  end

  // Outputs keep showing the last valid head once the queue drains or is flushed.
  always_ff @(posedge clk) begin
    if (reset)          hold_q <= '0;
    else if (out_valid) hold_q <= q_head;
  end

  assign out_inst = out_valid ? q_head.inst : hold_q.inst;
  assign out_pc   = out_valid ? q_head.pc   : hold_q.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushed <= perf_flushed + 32'(q_count) + 32'(inflight_q);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-of-PCs reference model, directed and random stimulus.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'(a >> 2);
  endfunction

  // Instruction memory: word k at byte address 4k, one-cycle read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= word(imem_addr);

  int checks = 0;
  int errors = 0;

  // Reference model: PCs held in the queue, the response arriving next cycle, next fetch PC.
  logic [7:0]  mq[$];
  bit          pend;
  logic [7:0]  pend_pc;
  logic [7:0]  mpc;
  bit          started;
  logic [7:0]  last_pc;
  logic [31:0] last_inst;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  int          cyc;
  int          got_cyc[$];
  logic [7:0]  got_pc[$];
  logic [31:0] got_inst[$];
  int          en_pulses;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend      = 1'b0;
    pend_pc   = '0;
    mpc       = 8'h00;
    started   = 1'b0;
    last_pc   = '0;
    last_inst = '0;
    m_fetched = '0;
    m_flushed = '0;
  endtask

  // One clock cycle: drive, compare at negedge, advance the model to the next edge.
  task automatic step(input bit rst, input bit rv, input logic [7:0] rpc, input bit rdy);
    bit exp_valid;
    bit exp_en;
    int occ;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    exp_valid = (mq.size() > 0);
    occ       = mq.size() + (pend ? 1 : 0) - ((exp_valid && rdy) ? 1 : 0);
    exp_en    = !rst && started && !rv && (occ < 4);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("imem_en", 64'(imem_en), 64'(exp_en));
    if (exp_en) chk("imem_addr", 64'(imem_addr), 64'(mpc));
    if (exp_valid) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0]));
      chk("out_inst", 64'(out_inst), 64'(word(mq[0])));
    end else begin
      chk("hold_pc", 64'(out_pc), 64'(last_pc));
      chk("hold_inst", 64'(out_inst), 64'(last_inst));
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
    if (out_valid && rdy) begin
      got_cyc.push_back(cyc);
      got_pc.push_back(out_pc);
      got_inst.push_back(out_inst);
    end
    if (imem_en) en_pulses++;

    if (rst) begin
      model_reset();
    end else begin
      started = 1'b1;
      if (exp_valid) begin
        last_pc   = mq[0];
        last_inst = word(mq[0]);
      end
      if (rv) begin
        m_flushed = m_flushed + 32'(mq.size()) + 32'(pend);
        mq.delete();
        pend = 1'b0;
        mpc  = rpc & 8'hFC;
      end else begin
        if (exp_valid && rdy) void'(mq.pop_front());
        if (pend) begin
          mq.push_back(pend_pc);
          m_fetched++;
        end
        pend    = exp_en;
        pend_pc = mpc;
        if (exp_en) mpc = mpc + 8'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic first_after(input int c0, output int idx);
    idx = -1;
    for (int i = 0; i < got_cyc.size(); i++)
      if (got_cyc[i] > c0) begin
        idx = i;
        break;
      end
  endtask

  task automatic clear_trace();
    got_cyc.delete();
    got_pc.delete();
    got_inst.delete();
    en_pulses = 0;
  endtask

  int base;
  int rc;
  int idx;
  logic [7:0] exp_seq[5];

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    model_reset();
    cyc = 0;
    clear_trace();
    @(posedge clk);
    #1;

    // Reset and free-run from RESET_PC.
    repeat (3) step(1, 0, 0, 1);
    chk("reset_out_pc", 64'(out_pc), 64'h0);
    chk("reset_out_inst", 64'(out_inst), 64'h0);
    clear_trace();
    base = cyc;
    repeat (10) step(0, 0, 0, 1);
    chk("free_first_cycle", 64'(got_cyc.size() > 0 ? got_cyc[0] - base : -1), 64'd3);
    for (int i = 0; i < 5; i++) begin
      chk("free_pc", 64'(got_pc.size() > i ? got_pc[i] : 8'hxx), 64'(i * 4));
      chk("free_inst", 64'(got_inst.size() > i ? got_inst[i] : 32'hx), 64'(i));
      if (i > 0) chk("free_gapless", 64'(got_cyc.size() > i ? got_cyc[i] - got_cyc[i-1] : -1), 64'd1);
    end

    // Backpressure: only QUEUE_DEPTH fetches while stalled, then an in-order stream.
    repeat (2) step(1, 0, 0, 0);
    clear_trace();
    repeat (10) step(0, 0, 0, 0);
    chk("stall_issues", 64'(en_pulses), 64'd4);
    chk("stall_nothing_out", 64'(got_pc.size()), 64'd0);
    repeat (8) step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      chk("release_pc", 64'(got_pc.size() > i ? got_pc[i] : 8'hxx), 64'(i * 4));

    // Misaligned redirect during free-run.
    rc = cyc;
    step(0, 1, 8'h43, 1);
    repeat (6) step(0, 0, 0, 1);
    first_after(rc, idx);
    chk("redir_first_cycle", 64'(idx >= 0 ? got_cyc[idx] - rc : -1), 64'd3);
    chk("redir_first_pc", 64'(idx >= 0 ? got_pc[idx] : 8'hxx), 64'h40);

    // Wrap at the top of the address space.
    rc = cyc;
    step(0, 1, 8'hFC, 1);
    repeat (7) step(0, 0, 0, 1);
    first_after(rc, idx);
    exp_seq[0] = 8'hFC; exp_seq[1] = 8'h00; exp_seq[2] = 8'h04;
    for (int i = 0; i < 3; i++)
      chk("wrap_pc", 64'(idx >= 0 && got_pc.size() > idx + i ? got_pc[idx + i] : 8'hxx), 64'(exp_seq[i]));

    // Back-to-back redirects: the later target wins.
    rc = cyc;
    step(0, 1, 8'h20, 1);
    step(0, 1, 8'h80, 1);
    repeat (6) step(0, 0, 0, 1);
    first_after(rc, idx);
    chk("b2b_first_pc", 64'(idx >= 0 ? got_pc[idx] : 8'hxx), 64'h80);
    chk("b2b_first_cycle", 64'(idx >= 0 ? got_cyc[idx] - rc : -1), 64'd4);

`ifdef FETCH_PERF_EN
    // Six enqueued, then a redirect with three queued and one in flight.
    repeat (2) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 8'h40, 0);
    @(negedge clk);
    chk("perf_fetched_lit", 64'(perf_fetched), 64'd6);
    chk("perf_flushed_lit", 64'(perf_flushed), 64'd4);
    @(posedge clk);
    #1;
`endif

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r_rst;
      bit r_rv;
      r_rst = ($urandom_range(0, 199) == 0);
      r_rv  = ($urandom_range(0, 99) < 6);
      step(r_rst, r_rv, 8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
